// File: rtl/scan_chain_arbiter.sv
// -----------------------------------------------------------------------------
// scan_chain_arbiter
//   Shares one scan-chain driver port between NUM_REQ requesters. Round-robin
//   request/grant with exclusive ownership; after every release the chain is
//   held in a safe idle state (clk/select/latch/data low) for a guard band
//   before the next owner is granted.
//
//   Optional feature: define SCAN_ARB_TIMEOUT_EN to build a watchdog that
//   revokes an owner holding the chain for MAX_HOLD consecutive cycles. A
//   revoked requester is masked from arbitration until it drops its request.
//   Without the macro, ownership is unbounded and timeout_pulse is tied low.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   req               level requests, held for the whole ownership
//   grant             registered one-hot grant, zero when unowned
//   owner_id          index of current owner, meaningful while busy=1
//   busy              high while a requester owns the chain
//   rq_scan_*         per-requester scan clock/data/select/latch
//   scan_*            registered scan-chain drive (owner's signals, 1-cycle late)
//   timeout_pulse     one-cycle pulse when the watchdog revokes an owner
// -----------------------------------------------------------------------------
module scan_chain_arbiter #(
   parameter int NUM_REQ      = 3,
   parameter int GUARD_CYCLES = 4,
   parameter int MAX_HOLD     = 256,
   parameter int IW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic [IW-1:0]      owner_id,
   output logic               busy,
   input  logic [NUM_REQ-1:0] rq_scan_clk,
   input  logic [NUM_REQ-1:0] rq_scan_data,
   input  logic [NUM_REQ-1:0] rq_scan_select,
   input  logic [NUM_REQ-1:0] rq_scan_latch,
   output logic               scan_clk_out,
   output logic               scan_data_out,
   output logic               scan_select,
   output logic               scan_latch_en,
   output logic               timeout_pulse
);

   // A guard band of zero would let two owners drive back to back.
   localparam int GUARD = (GUARD_CYCLES < 1) ? 1 : GUARD_CYCLES;
   localparam int GW    = $clog2(GUARD + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t             state_r, state_nxt_s;
   logic [NUM_REQ-1:0] grant_r, grant_nxt_s;
   logic [IW-1:0]      owner_r, owner_nxt_s;
   logic               busy_r, busy_nxt_s;
   logic [IW-1:0]      rr_r, rr_nxt_s;
   logic [GW-1:0]      guard_r, guard_nxt_s;
   // Packed as {clk, data, select, latch}.
   logic [3:0]         scan_r, scan_nxt_s;

   logic [NUM_REQ-1:0] elig_s;
   logic [IW-1:0]      pick_s;
   logic               found_s;
   logic [3:0]         pick_scan_s;
   logic [3:0]         own_scan_s;
   logic               owner_req_s;

`ifdef SCAN_ARB_TIMEOUT_EN
   localparam int HW = $clog2(MAX_HOLD + 1);

   logic [HW-1:0]      hold_r, hold_nxt_s;
   logic [NUM_REQ-1:0] mask_r, mask_nxt_s;
   logic               tpulse_r, tpulse_nxt_s;

   assign elig_s        = req & ~mask_r;
   assign timeout_pulse = tpulse_r;
`else
   assign elig_s        = req;
   assign timeout_pulse = 1'b0;
`endif

   function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] k);
      logic [NUM_REQ-1:0] v;
      v    = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   // Priority pointer moves to the requester just after the new owner.
   function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] k);
      logic [IW-1:0] p;
      if (k == IW'(NUM_REQ - 1)) begin
         p = '0;
      end else begin
         p = k + IW'(1);
      end
      return p;
   endfunction

   assign pick_scan_s = {rq_scan_clk[pick_s], rq_scan_data[pick_s],
                         rq_scan_select[pick_s], rq_scan_latch[pick_s]};
   assign own_scan_s  = {rq_scan_clk[owner_r], rq_scan_data[owner_r],
                         rq_scan_select[owner_r], rq_scan_latch[owner_r]};
   assign owner_req_s = req[owner_r];

   // Round-robin search: first eligible requester at or after the pointer, wrapping.
   always_comb begin
      int idx;
      idx     = 0;
      pick_s  = '0;
      found_s = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(rr_r) + i;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end else begin
            idx = idx;
         end
         if (!found_s && elig_s[IW'(idx)]) begin
            found_s = 1'b1;
            pick_s  = IW'(idx);
         end else begin
            found_s = found_s;
         end
      end
   end

   // Next-state and next-output decode for the ownership FSM.
   always_comb begin
      state_nxt_s  = state_r;
      grant_nxt_s  = grant_r;
      owner_nxt_s  = owner_r;
      busy_nxt_s   = busy_r;
      rr_nxt_s     = rr_r;
      guard_nxt_s  = guard_r;
      scan_nxt_s   = 4'b0000;
`ifdef SCAN_ARB_TIMEOUT_EN
      hold_nxt_s   = hold_r;
      // A masked requester becomes eligible again once it lets go of req.
      mask_nxt_s   = mask_r & req;
      tpulse_nxt_s = 1'b0;
`endif
      case (state_r)
         ST_IDLE: begin
            if (found_s) begin
               state_nxt_s = ST_GRANT;
               grant_nxt_s = onehot(pick_s);
               owner_nxt_s = pick_s;
               busy_nxt_s  = 1'b1;
               rr_nxt_s    = next_ptr(pick_s);
               guard_nxt_s = '0;
               // The granting edge already forwards the new owner's signals.
               scan_nxt_s  = pick_scan_s;
`ifdef SCAN_ARB_TIMEOUT_EN
               hold_nxt_s  = '0;
`endif
            end else begin
               grant_nxt_s = '0;
               busy_nxt_s  = 1'b0;
            end
         end
         ST_GRANT: begin
            // Release wins over a simultaneous watchdog expiry.
            if (!owner_req_s) begin
               state_nxt_s = ST_DRAIN;
               grant_nxt_s = '0;
               busy_nxt_s  = 1'b0;
               guard_nxt_s = '0;
            end else begin
`ifdef SCAN_ARB_TIMEOUT_EN
               if (hold_r == HW'(MAX_HOLD - 1)) begin
                  state_nxt_s  = ST_DRAIN;
                  grant_nxt_s  = '0;
                  busy_nxt_s   = 1'b0;
                  guard_nxt_s  = '0;
                  tpulse_nxt_s = 1'b1;
                  mask_nxt_s   = (mask_r & req) | onehot(owner_r);
               end else begin
                  hold_nxt_s   = hold_r + HW'(1);
                  scan_nxt_s   = own_scan_s;
               end
`else
               scan_nxt_s = own_scan_s;
`endif
            end
         end
         ST_DRAIN: begin
            if (guard_r == GW'(GUARD - 1)) begin
               state_nxt_s = ST_IDLE;
               guard_nxt_s = '0;
            end else begin
               guard_nxt_s = guard_r + GW'(1);
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            grant_nxt_s = '0;
            busy_nxt_s  = 1'b0;
            guard_nxt_s = '0;
         end
      endcase
   end

   // State and registered-output update; async reset parks the chain idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r  <= ST_IDLE;
         grant_r  <= '0;
         owner_r  <= '0;
         busy_r   <= 1'b0;
         rr_r     <= '0;
         guard_r  <= '0;
         scan_r   <= 4'b0000;
`ifdef SCAN_ARB_TIMEOUT_EN
         hold_r   <= '0;
         mask_r   <= '0;
         tpulse_r <= 1'b0;
`endif
      end else begin
         state_r  <= state_nxt_s;
         grant_r  <= grant_nxt_s;
         owner_r  <= owner_nxt_s;
         busy_r   <= busy_nxt_s;
         rr_r     <= rr_nxt_s;
         guard_r  <= guard_nxt_s;
         scan_r   <= scan_nxt_s;
`ifdef SCAN_ARB_TIMEOUT_EN
         hold_r   <= hold_nxt_s;
         mask_r   <= mask_nxt_s;
         tpulse_r <= tpulse_nxt_s;
`endif
      end
   end

   assign grant         = grant_r;
   assign owner_id      = owner_r;
   assign busy          = busy_r;
   assign scan_clk_out  = scan_r[3];
   assign scan_data_out = scan_r[2];
   assign scan_select   = scan_r[1];
   assign scan_latch_en = scan_r[0];

endmodule

// File: tb/tb_scan_chain_arbiter.sv
`timescale 1ns/1ps
module tb_scan_chain_arbiter;

   localparam int N     = 3;
   localparam int GUARD = 4;
   localparam int MAXH  = 16;
`ifdef SCAN_ARB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic         clk;
   logic         reset;
   logic [N-1:0] req;
   logic [N-1:0] grant;
   logic [1:0]   owner_id;
   logic         busy;
   logic [N-1:0] rq_scan_clk, rq_scan_data, rq_scan_select, rq_scan_latch;
   logic         scan_clk_out, scan_data_out, scan_select, scan_latch_en;
   logic         timeout_pulse;

   int checks = 0;
   int errors = 0;

   scan_chain_arbiter #(
      .NUM_REQ(N), .GUARD_CYCLES(GUARD), .MAX_HOLD(MAXH)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .grant(grant), .owner_id(owner_id),
      .busy(busy), .rq_scan_clk(rq_scan_clk), .rq_scan_data(rq_scan_data),
      .rq_scan_select(rq_scan_select), .rq_scan_latch(rq_scan_latch),
      .scan_clk_out(scan_clk_out), .scan_data_out(scan_data_out),
      .scan_select(scan_select), .scan_latch_en(scan_latch_en),
      .timeout_pulse(timeout_pulse)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout simulation did not finish in time");
      $fatal(1);
   end

   // Reference model: who owns the chain, remaining guard cycles, whose turn it is.
   int           m_owner;   // -1 when nobody owns the chain
   int           m_last;
   int           m_drain;   // guard cycles still to run
   int           m_prio;    // requester with highest priority next time
   int           m_hold;    // grant cycles elapsed for the current owner
   logic [N-1:0] m_mask;
   logic [2:0]   e_grant;
   logic         e_busy;
   logic [1:0]   e_owner;
   logic [3:0]   e_scan;
   logic         e_tp;

   logic [10:0] obs_s, exp_s;
   assign obs_s = {grant, busy, (busy ? owner_id : 2'b00),
                   scan_clk_out, scan_data_out, scan_select, scan_latch_en, timeout_pulse};
   assign exp_s = {e_grant, e_busy, (e_busy ? e_owner : 2'b00), e_scan, e_tp};

   function automatic logic bitof(input logic [N-1:0] v, input int i);
      return 1'((v >> i) & 3'b001);
   endfunction

   task automatic model_reset();
      m_owner = -1; m_last = 0; m_drain = 0; m_prio = 0; m_hold = 0;
      m_mask = '0;
      e_grant = '0; e_busy = 1'b0; e_owner = '0; e_scan = '0; e_tp = 1'b0;
   endtask

   task automatic model_update();
      logic [N-1:0] r;
      r      = req;
      e_tp   = 1'b0;
      m_mask = m_mask & r;
      if (m_owner >= 0) begin
         if (!bitof(r, m_owner)) begin
            m_owner = -1;
            m_drain = GUARD;
         end else if (TMO_EN && (m_hold + 1 >= MAXH)) begin
            m_mask  = m_mask | 3'(1 << m_owner);
            m_owner = -1;
            m_drain = GUARD;
            e_tp    = 1'b1;
         end else begin
            m_hold = m_hold + 1;
         end
      end else if (m_drain > 0) begin
         m_drain = m_drain - 1;
      end else begin
         for (int i = 0; i < N; i++) begin
            int k;
            k = (m_prio + i) % N;
            if (m_owner < 0 && bitof(r, k) && !bitof(m_mask, k)) begin
               m_owner = k;
               m_last  = k;
               m_hold  = 0;
               m_prio  = (k + 1) % N;
            end
         end
      end
      if (m_owner >= 0) begin
         e_grant = 3'(1 << m_owner);
         e_busy  = 1'b1;
         e_owner = 2'(m_last);
         e_scan  = {bitof(rq_scan_clk, m_owner), bitof(rq_scan_data, m_owner),
                    bitof(rq_scan_select, m_owner), bitof(rq_scan_latch, m_owner)};
      end else begin
         e_grant = '0;
         e_busy  = 1'b0;
         e_scan  = '0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic randomize_scan();
      rq_scan_clk    = 3'($urandom);
      rq_scan_data   = 3'($urandom);
      rq_scan_select = 3'($urandom);
      rq_scan_latch  = 3'($urandom);
   endtask

   task automatic do_reset();
      req = '0;
      rq_scan_clk = '0; rq_scan_data = '0; rq_scan_select = '0; rq_scan_latch = '0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      model_reset();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (obs_s !== 11'b0) begin
         errors++;
         $display("FAIL reset_outputs got %b want %b", obs_s, 11'b0);
      end
      step();
      checks++;
      if (obs_s !== exp_s) begin
         errors++;
         $display("FAIL idle_no_req got %b want %b", obs_s, exp_s);
      end
   endtask

   task automatic test_first_grant();
      logic prev;
      req = 3'b110;
      step();
      checks++;
      if (grant !== 3'b010) begin
         errors++;
         $display("FAIL first_grant got %b want %b", grant, 3'b010);
      end
      checks++;
      if (owner_id !== 2'd1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL first_owner got id=%0d busy=%b want id=1 busy=1", owner_id, busy);
      end
      for (int i = 0; i < 8; i++) begin
         randomize_scan();
         rq_scan_clk[1] = (i % 2 == 1);
         prev = rq_scan_clk[1];
         step();
         checks++;
         if (scan_clk_out !== prev) begin
            errors++;
            $display("FAIL clk_follow got %b want %b", scan_clk_out, prev);
         end
         checks++;
         if (obs_s !== exp_s) begin
            errors++;
            $display("FAIL model_follow got %b want %b", obs_s, exp_s);
         end
      end
   endtask

   task automatic test_release_rr();
      int gap, bad;
      bit done;
      gap = 0; bad = 0; done = 1'b0;
      req = 3'b101;
      for (int c = 0; c < 20 && !done; c++) begin
         randomize_scan();
         step();
         checks++;
         if (obs_s !== exp_s) begin
            errors++;
            $display("FAIL model_release got %b want %b", obs_s, exp_s);
         end
         if (grant == 3'b000) begin
            gap++;
            if ({scan_clk_out, scan_data_out, scan_select, scan_latch_en} != 4'b0000) bad++;
         end else begin
            done = 1'b1;
         end
      end
      checks++;
      if (!done || grant !== 3'b100) begin
         errors++;
         $display("FAIL rr_after_1 got %b want %b", grant, 3'b100);
      end
      // Guard band plus the one arbitration cycle in IDLE.
      checks++;
      if (gap != GUARD + 1 || bad != 0) begin
         errors++;
         $display("FAIL guard_gap got gap=%0d nonzero=%0d want gap=%0d nonzero=0", gap, bad, GUARD + 1);
      end
      req = 3'b001;
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         randomize_scan();
         step();
         checks++;
         if (obs_s !== exp_s) begin
            errors++;
            $display("FAIL model_wrap got %b want %b", obs_s, exp_s);
         end
         if (grant != 3'b000) done = 1'b1;
      end
      checks++;
      if (!done || grant !== 3'b001) begin
         errors++;
         $display("FAIL rr_wrap got %b want %b", grant, 3'b001);
      end
   endtask

   task automatic test_round_robin();
      int order[$];
      int prev, held, multi;
      do_reset();
      req = 3'b111; prev = -1; held = 0; multi = 0;
      for (int c = 0; c < 60; c++) begin
         randomize_scan();
         step();
         checks++;
         if (obs_s !== exp_s) begin
            errors++;
            $display("FAIL model_rr got %b want %b", obs_s, exp_s);
         end
         if ($countones(grant) > 1) multi++;
         if (m_owner >= 0) begin
            if (prev < 0) begin
               order.push_back(m_owner);
               held = 0;
            end
            held++;
            req = (held == 2) ? (3'b111 & ~3'(1 << m_owner)) : 3'b111;
         end else begin
            req = 3'b111;
         end
         prev = m_owner;
      end
      for (int j = 0; j < 6; j++) begin
         checks++;
         if (order.size() <= j || order[j] != j % 3) begin
            errors++;
            $display("FAIL rr_order idx=%0d got %0d want %0d", j,
                     (order.size() > j) ? order[j] : -1, j % 3);
         end
      end
      checks++;
      if (multi != 0) begin
         errors++;
         $display("FAIL onehot got %0d multi-bit cycles want 0", multi);
      end
   endtask

   task automatic test_timeout();
      int pulses, pulse_at;
      bit done;
      do_reset();
      req = 3'b001; pulses = 0; pulse_at = -1;
      for (int c = 0; c < 26; c++) begin
         randomize_scan();
         step();
         checks++;
         if (obs_s !== exp_s) begin
            errors++;
            $display("FAIL model_hold got %b want %b", obs_s, exp_s);
         end
         if (timeout_pulse) begin
            pulses++;
            pulse_at = c;
         end
      end
`ifdef SCAN_ARB_TIMEOUT_EN
      checks++;
      if (pulses != 1 || pulse_at != MAXH) begin
         errors++;
         $display("FAIL timeout_pulse got count=%0d at=%0d want count=1 at=%0d", pulses, pulse_at, MAXH);
      end
      checks++;
      if (grant !== 3'b000) begin
         errors++;
         $display("FAIL masked_no_regrant got %b want %b", grant, 3'b000);
      end
      req = 3'b000;
      step();
      req = 3'b001;
      done = 1'b0;
      for (int c = 0; c < 10 && !done; c++) begin
         step();
         if (grant != 3'b000) done = 1'b1;
      end
      checks++;
      if (!done || grant !== 3'b001) begin
         errors++;
         $display("FAIL regrant_after_drop got %b want %b", grant, 3'b001);
      end
`else
      done = 1'b1;
      checks++;
      if (pulses != 0 || grant !== 3'b001 || !done) begin
         errors++;
         $display("FAIL unbounded_hold got pulses=%0d grant=%b want pulses=0 grant=001", pulses, grant);
      end
`endif
   endtask

   task automatic test_reset_mid_grant();
      do_reset();
      req = 3'b111;
      rq_scan_clk = 3'b111; rq_scan_data = 3'b111; rq_scan_select = 3'b111; rq_scan_latch = 3'b111;
      step();
      step();
      checks++;
      if (scan_select !== 1'b1 || grant !== 3'b001) begin
         errors++;
         $display("FAIL pre_reset_select got sel=%b grant=%b want sel=1 grant=001", scan_select, grant);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (obs_s !== 11'b0 || owner_id !== 2'd0) begin
         errors++;
         $display("FAIL async_reset got %b id=%0d want all zero", obs_s, owner_id);
      end
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      step();
      checks++;
      if (grant !== 3'b001 || obs_s !== exp_s) begin
         errors++;
         $display("FAIL post_reset_grant got %b want %b", obs_s, exp_s);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] r;
      do_reset();
      for (int c = 0; c < 800; c++) begin
         r = req;
         for (int k = 0; k < N; k++) begin
            if (!bitof(r, k)) begin
               if ($urandom_range(2, 0) == 0) r = r | 3'(1 << k);
            end else if (m_owner == k) begin
               if ($urandom_range(5, 0) == 0) r = r & ~3'(1 << k);
            end else if ($urandom_range(15, 0) == 0) begin
               r = r & ~3'(1 << k);
            end
         end
         req = r;
         randomize_scan();
         step();
         checks++;
         if (obs_s !== exp_s) begin
            errors++;
            $display("FAIL model_random cycle=%0d got %b want %b", c, obs_s, exp_s);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      req = '0;
      rq_scan_clk = '0; rq_scan_data = '0; rq_scan_select = '0; rq_scan_latch = '0;
      model_reset();
      test_reset();
      test_first_grant();
      test_release_rr();
      test_round_robin();
      test_timeout();
      test_reset_mid_grant();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
